// File: rtl/timer_pkg.sv
// +----------------------------------------------------------------------------+
// | timer_pkg : mode encoding shared by timer_bank and timer_channel            |
// | Revision  : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

package timer_pkg;

  typedef enum logic [1:0] {
    TIMER_ALARM   = 2'd0,
    TIMER_TIMEOUT = 2'd1,
    TIMER_PULSE   = 2'd2,
    TIMER_STROBE  = 2'd3
  } timer_mode_e;

endpackage

`default_nettype wire

// File: rtl/timer_channel.sv
// +----------------------------------------------------------------------------+
// | timer_channel : one down-counting timer channel (alarm/timeout/pulse/strobe)|
// | Revision      : 1.0                                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

module timer_channel
  import timer_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic         tick,
  input  logic [W-1:0] value,
  input  timer_mode_e  mode,
  output logic         out,
  output logic         busy
);

  logic [W-1:0] count;
  logic [W-1:0] reload;
  timer_mode_e  mode_r;
  logic         expire;

  // A busy channel always holds count >= 1, so the tick that sees 1 is expiry.
  assign expire = tick && busy && (count == W'(1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count  <= '0;
      reload <= '0;
      mode_r <= TIMER_ALARM;
      out    <= 1'b0;
      busy   <= 1'b0;
    end else if (load) begin
      count  <= value;
      reload <= value;
      mode_r <= mode;
      busy   <= (value != '0);
      out    <= (value != '0) && (mode == TIMER_PULSE);
    end else begin
      unique case (mode_r)
        TIMER_ALARM:   out <= expire;
        TIMER_TIMEOUT: if (expire) out <= 1'b1;
        TIMER_PULSE:   if (expire) out <= 1'b0;
        TIMER_STROBE:  out <= expire;
      endcase

      if (tick && busy) begin
        if (count == W'(1)) begin
          if (mode_r == TIMER_STROBE) begin
            count <= reload;
          end else begin
            count <= '0;
            busy  <= 1'b0;
          end
        end else begin
          count <= count - W'(1);
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/timer_bank.sv
// +----------------------------------------------------------------------------+
// | timer_bank : N-channel timer with shared load port and optional prescaler   |
// |              (prescaler enabled by defining TIMER_PRESCALE_EN)              |
// | Revision   : 1.0                                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module timer_bank
  import timer_pkg::*;
#(
  parameter  int W        = 8,
  parameter  int N        = 4,
  parameter  int PRESCALE = 1,
  localparam int SEL_W    = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [W-1:0]     value,
  input  logic [1:0]       mode,
  input  logic [SEL_W-1:0] sel,
  input  logic             put,
  output logic [N-1:0]     out,
  output logic [N-1:0]     busy
);

  logic         tick;
  logic [N-1:0] load;

`ifdef TIMER_PRESCALE_EN
  localparam int             PW     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]  P_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] div;

  // Free-running; loads never resynchronise it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div <= '0;
    end else if (div == P_LAST) begin
      div <= '0;
    end else begin
      div <= div + PW'(1);
    end
  end

  assign tick = (div == P_LAST);
`else
  // Every edge ticks; PRESCALE is always >= 1 so this is constant high.
  assign tick = (PRESCALE >= 1);
`endif

  for (genvar k = 0; k < N; k++) begin : g_ch
    assign load[k] = put && (sel == SEL_W'(k));

    timer_channel #(
      .W (W)
    ) u_ch (
      .clock (clock),
      .reset (reset),
      .load  (load[k]),
      .tick  (tick),
      .value (value),
      .mode  (timer_mode_e'(mode)),
      .out   (out[k]),
      .busy  (busy[k])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_timer_bank.sv
// +----------------------------------------------------------------------------+
// | tb_timer_bank : directed table-driven bench for timer_bank (N=5, W=8)       |
// | Revision      : 1.0                                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_timer_bank;
  import timer_pkg::*;

  localparam int W = 8;
  localparam int N = 5;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] value = '0;
  logic [1:0]   mode  = 2'd0;
  logic [2:0]   sel   = 3'd0;
  logic         put   = 1'b0;
  logic [N-1:0] out;
  logic [N-1:0] busy;

  int errors = 0;
  int checks = 0;

  timer_bank #(.W(W), .N(N), .PRESCALE(4)) dut (
    .clock (clock),
    .reset (reset),
    .value (value),
    .mode  (mode),
    .sel   (sel),
    .put   (put),
    .out   (out),
    .busy  (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit           put;
    logic [2:0]   sel;
    logic [W-1:0] value;
    logic [1:0]   mode;
    int           n;
    logic [N-1:0] eo;
    logic [N-1:0] eb;
  } vec_t;

  vec_t rows[$];

  function automatic vec_t mk(bit p, logic [2:0] s, logic [W-1:0] v, logic [1:0] m,
                              int n, logic [N-1:0] eo, logic [N-1:0] eb);
    vec_t r;
    r.put = p; r.sel = s; r.value = v; r.mode = m; r.n = n; r.eo = eo; r.eb = eb;
    return r;
  endfunction

  task automatic check(input string name, input logic [N-1:0] eo, input logic [N-1:0] eb);
    checks++;
    if (out !== eo || busy !== eb) begin
      errors++;
      $display("FAIL %s: out=%b busy=%b required out=%b busy=%b", name, out, busy, eo, eb);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    #20;
    check("reset_low", 5'b00000, 5'b00000);
    @(negedge clock);
    reset = 1'b1;
    check("reset_release", 5'b00000, 5'b00000);

`ifdef TIMER_PRESCALE_EN
    begin
      int first_hi = -1;
      int hi_cycles = 0;
      put = 1'b1; sel = 3'd0; value = 8'd3; mode = TIMER_ALARM;
      step();
      put = 1'b0;
      check("pre_load", 5'b00000, 5'b00001);
      for (int k = 2; k <= 16; k++) begin
        step();
        if (out[0]) begin
          hi_cycles++;
          if (first_hi < 0) first_hi = k;
        end
      end
      checks++;
      if (first_hi < 9 || first_hi > 12) begin
        errors++;
        $display("FAIL pre_expiry_edge: got %0d required 9..12", first_hi);
      end
      checks++;
      if (hi_cycles != 1) begin
        errors++;
        $display("FAIL pre_pulse_width: got %0d required 1", hi_cycles);
      end
      check("pre_idle", 5'b00000, 5'b00000);
    end
`else
    // ch0 alarm V=17
    rows.push_back(mk(1, 0, 17, TIMER_ALARM,   1, 5'b00000, 5'b00001));
    rows.push_back(mk(0, 0, 0,  TIMER_ALARM,  16, 5'b00000, 5'b00001));
    rows.push_back(mk(0, 0, 0,  TIMER_ALARM,   1, 5'b00001, 5'b00000));
    rows.push_back(mk(0, 0, 0,  TIMER_ALARM,   2, 5'b00000, 5'b00000));
    // ch1 pulse V=7 then ch2 timeout V=7 on the next edge
    rows.push_back(mk(1, 1, 7,  TIMER_PULSE,   1, 5'b00010, 5'b00010));
    rows.push_back(mk(1, 2, 7,  TIMER_TIMEOUT, 1, 5'b00010, 5'b00110));
    rows.push_back(mk(0, 0, 0,  TIMER_ALARM,   5, 5'b00010, 5'b00110));
    rows.push_back(mk(0, 0, 0,  TIMER_ALARM,   1, 5'b00000, 5'b00100));
    rows.push_back(mk(0, 0, 0,  TIMER_ALARM,   1, 5'b00100, 5'b00000));
    rows.push_back(mk(0, 0, 0,  TIMER_ALARM,   3, 5'b00100, 5'b00000));
    // ch3 strobe V=3, then cancel
    rows.push_back(mk(1, 3, 3,  TIMER_STROBE,  1, 5'b00100, 5'b01000));
    rows.push_back(mk(0, 0, 0,  TIMER_ALARM,   2, 5'b00100, 5'b01000));
    rows.push_back(mk(0, 0, 0,  TIMER_ALARM,   1, 5'b01100, 5'b01000));
    rows.push_back(mk(0, 0, 0,  TIMER_ALARM,   2, 5'b00100, 5'b01000));
    rows.push_back(mk(0, 0, 0,  TIMER_ALARM,   1, 5'b01100, 5'b01000));
    rows.push_back(mk(0, 0, 0,  TIMER_ALARM,   1, 5'b00100, 5'b01000));
    rows.push_back(mk(1, 3, 0,  TIMER_STROBE,  1, 5'b00100, 5'b00000));
    rows.push_back(mk(0, 0, 0,  TIMER_ALARM,   5, 5'b00100, 5'b00000));
    // ch4 alarm V=5, re-put on the expiry edge
    rows.push_back(mk(1, 4, 5,  TIMER_ALARM,   1, 5'b00100, 5'b10000));
    rows.push_back(mk(0, 0, 0,  TIMER_ALARM,   4, 5'b00100, 5'b10000));
    rows.push_back(mk(1, 4, 5,  TIMER_ALARM,   1, 5'b00100, 5'b10000));
    rows.push_back(mk(0, 0, 0,  TIMER_ALARM,   4, 5'b00100, 5'b10000));
    rows.push_back(mk(0, 0, 0,  TIMER_ALARM,   1, 5'b10100, 5'b00000));
    rows.push_back(mk(0, 0, 0,  TIMER_ALARM,   1, 5'b00100, 5'b00000));
    // out-of-range selects
    rows.push_back(mk(1, 5, 3,  TIMER_PULSE,   1, 5'b00100, 5'b00000));
    rows.push_back(mk(1, 7, 2,  TIMER_TIMEOUT, 1, 5'b00100, 5'b00000));
    rows.push_back(mk(0, 0, 0,  TIMER_ALARM,   4, 5'b00100, 5'b00000));
    // reload held timeout: out forced low, then rises again
    rows.push_back(mk(1, 2, 2,  TIMER_TIMEOUT, 1, 5'b00000, 5'b00100));
    rows.push_back(mk(0, 0, 0,  TIMER_ALARM,   1, 5'b00000, 5'b00100));
    rows.push_back(mk(0, 0, 0,  TIMER_ALARM,   1, 5'b00100, 5'b00000));
    // strobe V=1 is constantly high, then cancel
    rows.push_back(mk(1, 1, 1,  TIMER_STROBE,  1, 5'b00100, 5'b00010));
    rows.push_back(mk(0, 0, 0,  TIMER_ALARM,   4, 5'b00110, 5'b00010));
    rows.push_back(mk(1, 1, 0,  TIMER_ALARM,   1, 5'b00100, 5'b00000));
    // pulse cancelled mid-count
    rows.push_back(mk(1, 0, 6,  TIMER_PULSE,   1, 5'b00101, 5'b00001));
    rows.push_back(mk(0, 0, 0,  TIMER_ALARM,   2, 5'b00101, 5'b00001));
    rows.push_back(mk(1, 0, 0,  TIMER_PULSE,   1, 5'b00100, 5'b00000));
    rows.push_back(mk(0, 0, 0,  TIMER_ALARM,   3, 5'b00100, 5'b00000));

    foreach (rows[i]) begin
      put = rows[i].put; sel = rows[i].sel; value = rows[i].value; mode = rows[i].mode;
      for (int c = 0; c < rows[i].n; c++) begin
        step();
        put = 1'b0;
        check($sformatf("row%0d_cyc%0d", i, c), rows[i].eo, rows[i].eb);
      end
    end

    // async reset in the middle of an alarm V=10 count
    put = 1'b1; sel = 3'd0; value = 8'd10; mode = TIMER_ALARM;
    step();
    put = 1'b0;
    check("rst_seq_load", 5'b00100, 5'b00001);
    repeat (3) step();
    #2 reset = 1'b0;
    #1 check("rst_async_now", 5'b00000, 5'b00000);
    step();
    check("rst_held", 5'b00000, 5'b00000);
    reset = 1'b1;
    put = 1'b1; sel = 3'd0; value = 8'd2; mode = TIMER_ALARM;
    step();
    put = 1'b0;
    check("rst_first_load", 5'b00000, 5'b00001);
    step();
    check("rst_count", 5'b00000, 5'b00001);
    step();
    check("rst_new_expiry", 5'b00001, 5'b00000);
    for (int c = 0; c < 10; c++) begin
      step();
      check($sformatf("rst_quiet%0d", c), 5'b00000, 5'b00000);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/timer_bank.md
# timer_bank

Parametrised multi-channel timer: N independent down-counting channels, each loaded through one shared write port and running in one of four modes (alarm, timeout, pulse, strobe). It is the next generation of the single-purpose timers in the timer library: one block serves every mode with configurable counter width and channel count, per-channel busy status and an optional shared prescaler. It sits beside the CPU/peripheral glue, which loads it through `put`.

## Interface

- `W`, 8: counter and `value` width in bits (≥ 2).
- `N`, 4: channel count (1..16).
- `PRESCALE`, 1: tick divider (≥ 1); used only with `TIMER_PRESCALE_EN`.

- `clock`  in  1  rising-edge clock.
- `reset`  in  1  one clock; reset is asynchronous and active-low.
- `value`  in  W  period/duration to load; 0 cancels the channel.
- `mode`   in  2  mode to load: 0 alarm, 1 timeout, 2 pulse, 3 strobe.
- `sel`    in  max(1,$clog2(N))  target channel; values ≥ N ignored.
- `put`    in  1  load strobe, sampled on rising `clock`.
- `out`    out N  per-channel timer output, registered.
- `busy`   out N  per-channel counting flag, registered.

## Operation

- Per channel: count register (W), mode register (2), `out`, `busy`.
- While `reset` low: all counts, modes, `out`, `busy` = 0; prescaler = 0.
- Load: `put`=1 at edge E0 with `sel`=k<N → channel k count := `value`, mode := `mode`, `busy`[k] := (`value`≠0). Other channels unaffected.
- Load with `value`=0: cancel; `out`[k]=0, `busy`[k]=0, channel idle.
- Tick (every edge without macro): each busy channel not being loaded decrements; reaching 0 is expiry.
- Alarm: `out` 0 at load; on expiry `out`=1 for exactly one cycle; `busy` clears.
- Timeout: `out` 0 at load; on expiry `out`=1 and held until next load of that channel; `busy` clears.
- Pulse: `out`=1 from load; `out`=0 and `busy`=0 at expiry.
- Strobe: on expiry `out`=1 for one cycle, count reloads with loaded value, `busy` stays 1; runs until cancelled or reloaded. Loaded value kept in a per-channel reload register.
- Reload while active: restart with new value/mode; any pending expiry in that cycle is dropped (load wins). Alarm/strobe/timeout `out` forced 0 on the load edge; pulse forced 1.
- `sel` ≥ N with `put`: no effect.
- Arithmetic unsigned, W bits; no wrap — count never decrements below 0.

## Timing

- Value V≥1, no prescaler, load at edge E0:
  - alarm: `out` high between E0+V and E0+V+1.
  - timeout: `out` rises at E0+V, stays high.
  - pulse: `out` high from E0 to E0+V (V cycles).
  - strobe: `out` high one cycle after E0+V, E0+2V, …; V=1 → `out` constantly 1.
- `busy` rises at E0, falls at the expiry edge (never for strobe).
- Async `reset` assertion mid-count: outputs 0 immediately, no expiry on release; first load accepted at first edge after release.

## Configuration

- `TIMER_PRESCALE_EN` defined: shared free-running divider counts 0..PRESCALE-1; tick asserted on the edge where it wraps. Counts decrement only on ticks; loads take effect on any edge; expiry at the V-th tick edge after load. Divider not reset by `put`, so first tick latency is 1..PRESCALE cycles.
- Not defined: no divider logic; every edge is a tick; `PRESCALE` ignored.

## Structure

- Package `timer_pkg`: mode constants `TIMER_ALARM`=0, `TIMER_TIMEOUT`=1, `TIMER_PULSE`=2, `TIMER_STROBE`=3; 2-bit mode type.
- Sub-module `timer_channel` (W-parameterised: load, tick, value, mode → out, busy) instantiated N times in a generate loop; prescaler and `sel` decode stay in `timer_bank`.

## Test plan

- Reset low 20 ns, release; `put` ch0 alarm V=17 → `out`[0] single-cycle pulse 17 edges after load, `busy`[0] high for 17 cycles.
- ch1 pulse V=7 and ch2 timeout V=7 loaded on consecutive edges → `out`[1] high 7 cycles; `out`[2] rises 7 edges after its load and stays high; ch0 untouched.
- ch3 strobe V=3 → `out`[3] pulses every 3 cycles; reload ch3 V=0 → `out`[3]=0, `busy`[3]=0, no further pulses.
- Alarm V=5, re-put V=5 on the expiry edge → no pulse that cycle; pulse 5 edges after re-put.
- `put` with `sel`=N (out of range) → no output or busy change; reset asserted mid-count of alarm V=10 → `out`,`busy` 0 immediately, no pulse after release.
- With `TIMER_PRESCALE_EN`, PRESCALE=4, alarm V=3 → pulse on 3rd tick after load (9..12 cycles).
